truth_table_sweeper: RTL and testbench

//  Upstream stimulus and checker stage for the Guia_05 gate-level exercises.
//  On start, walks every input vector of an N_IN-input combinational function in ascending order.

---
 rtl/guia05_pkg.sv | 13 +
 rtl/truth_table_sweeper_if.sv | 28 ++
 rtl/settle_timer.sv | 33 +++
 rtl/truth_table_sweeper.sv | 118 +++++++++++
 tb/tb_truth_table_sweeper.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/guia05_pkg.sv
// Shared definitions for the Guia_05 truth-table sweeper: FSM encoding and limits.
package guia05_pkg;

   localparam int MAX_N_IN = 8;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRIVE  = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Stimulus/result bundle between the sweeper and the two implementations under test.
interface truth_table_sweeper_if #(
   parameter int N_IN = 2
);

   logic            start;
   logic            fa;
   logic            fb;
   logic [N_IN-1:0] vec;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_IN:0]   mismatch_count;
   logic [N_IN-1:0] first_bad;
   logic            bad_valid;

   // master drives start and returns fa/fb; slave is the sweeper itself
   modport master (
      output start, fa, fb,
      input  vec, busy, done, pass, mismatch_count, first_bad, bad_valid
   );

   modport slave (
      input  start, fa, fb,
      output vec, busy, done, pass, mismatch_count, first_bad, bad_valid
   );

endinterface

// File: rtl/settle_timer.sv
// Counts cycles a vector has been held; expire flags the last settle cycle.
module settle_timer #(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic expire
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear)
         count_d = '0;
      else if (en)
         count_d = count_q + CW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign expire = (count_q == CW'(SETTLE - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks all 2**N_IN input vectors, compares two implementations after a settle delay,
// and reports mismatch count, first failing vector and overall pass.
module truth_table_sweeper
   import guia05_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   truth_table_sweeper_if.slave  bus
);

   state_e          state_q, state_d;
   logic [N_IN-1:0] vec_q, vec_d;
   logic [N_IN-1:0] first_bad_q, first_bad_d;
   logic [N_IN:0]   cnt_q, cnt_d;
   logic            bad_valid_q, bad_valid_d;
   logic            pass_q, pass_d;

   logic timer_clear, timer_en, expire;
   logic last_vec, mismatch;

   settle_timer #(.SETTLE(SETTLE)) u_settle (
      .clk    (clk),
      .reset  (reset),
      .clear  (timer_clear),
      .en     (timer_en),
      .expire (expire)
   );

   assign last_vec = &vec_q;
   assign mismatch = bus.fa ^ bus.fb;

   // NOTE: every signal gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      vec_d       = vec_q;
      cnt_d       = cnt_q;
      first_bad_d = first_bad_q;
      bad_valid_d = bad_valid_q;
      pass_d      = pass_q;
      timer_clear = 1'b0;
      timer_en    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d     = S_DRIVE;
               vec_d       = '0;
               cnt_d       = '0;
               first_bad_d = '0;
               bad_valid_d = 1'b0;
               pass_d      = 1'b0;
               timer_clear = 1'b1;
            end
         end
         S_DRIVE: begin
            timer_en = 1'b1;
            if (expire) begin
               state_d     = S_SAMPLE;
               timer_clear = 1'b1;
            end
         end
         S_SAMPLE: begin
            if (mismatch) begin
               cnt_d = cnt_q + (N_IN+1)'(1);
               if (!bad_valid_q) begin
                  first_bad_d = vec_q;
                  bad_valid_d = 1'b1;
               end
            end
            // The all-ones vector ends the sweep in place rather than wrapping to zero.
            if (last_vec) begin
               state_d = S_DONE;
               pass_d  = (cnt_d == '0);
            end else begin
               state_d = S_DRIVE;
               vec_d   = vec_q + N_IN'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: registers use non-blocking assignments so each one loads pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         vec_q       <= '0;
         cnt_q       <= '0;
         first_bad_q <= '0;
         bad_valid_q <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         cnt_q       <= cnt_d;
         first_bad_q <= first_bad_d;
         bad_valid_q <= bad_valid_d;
         pass_q      <= pass_d;
      end
   end

   assign bus.vec            = vec_q;
   assign bus.busy           = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
   assign bus.done           = (state_q == S_DONE);
   assign bus.pass           = pass_q;
   assign bus.mismatch_count = cnt_q;
   assign bus.first_bad      = first_bad_q;
   assign bus.bad_valid      = bad_valid_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: three sweeper configurations driven by small gate-level functions.
module tb_truth_table_sweeper;

   logic clk = 1'b0;
   logic reset;
   logic mode_a;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   truth_table_sweeper_if #(.N_IN(2)) ifa ();
   truth_table_sweeper_if #(.N_IN(2)) ifb ();
   truth_table_sweeper_if #(.N_IN(3)) ifc ();

   truth_table_sweeper #(.N_IN(2), .SETTLE(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
   truth_table_sweeper #(.N_IN(2), .SETTLE(3)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
   truth_table_sweeper #(.N_IN(3), .SETTLE(1)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

   // A: fa is the NOR form of a&~b; fb is ~a&b (mode 0) or the expression form a&~b (mode 1)
   assign ifa.fa = ~(~ifa.vec[1] | ifa.vec[0]);
   assign ifa.fb = mode_a ? (ifa.vec[1] & ~ifa.vec[0]) : (~ifa.vec[1] & ifa.vec[0]);
   assign ifb.fa = ifb.vec[1] ^ ifb.vec[0];
   assign ifb.fb = (ifb.vec[1] & ~ifb.vec[0]) | (~ifb.vec[1] & ifb.vec[0]);
   assign ifc.fa = (ifc.vec[2] & ifc.vec[1]) | ifc.vec[0];
   assign ifc.fb = ~ifc.fa;

   task automatic start_a();
      ifa.start = 1'b1;
      @(posedge clk); #1;
      ifa.start = 1'b0;
   endtask

   task automatic wait_done_a(output int cycles);
      cycles = -1;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         if (ifa.done) begin
            cycles = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #3;
      total++; if (ifa.vec !== 2'b00) begin bad++; $display("FAIL reset_vec: got %0h want 0", ifa.vec); end
      total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", ifa.busy); end
      total++; if (ifa.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", ifa.done); end
      total++; if (ifa.pass !== 1'b0) begin bad++; $display("FAIL reset_pass: got %0b want 0", ifa.pass); end
      total++; if (ifa.mismatch_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", ifa.mismatch_count); end
      total++; if (ifa.first_bad !== 2'b00 || ifa.bad_valid !== 1'b0) begin
         bad++; $display("FAIL reset_first_bad: got %0h/%0b want 0/0", ifa.first_bad, ifa.bad_valid);
      end
      total++; if (ifc.vec !== 3'b000 || ifb.busy !== 1'b0) begin
         bad++; $display("FAIL reset_others: got vec_c=%0h busy_b=%0b want 0/0", ifc.vec, ifb.busy);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      total++; if (ifa.busy !== 1'b0 || ifa.vec !== 2'b00) begin
         bad++; $display("FAIL idle_after_reset: got busy=%0b vec=%0h want 0/0", ifa.busy, ifa.vec);
      end
   endtask

   task automatic test_mismatch_basic();
      int k;
      mode_a = 1'b0;
      start_a();
      total++; if (ifa.busy !== 1'b1) begin bad++; $display("FAIL t1_busy: got %0b want 1", ifa.busy); end
      wait_done_a(k);
      total++; if (k !== 8) begin bad++; $display("FAIL t1_latency: got %0d want 8", k); end
      total++; if (ifa.mismatch_count !== 3'd2) begin bad++; $display("FAIL t1_count: got %0d want 2", ifa.mismatch_count); end
      total++; if (ifa.first_bad !== 2'b01) begin bad++; $display("FAIL t1_first_bad: got %0h want 1", ifa.first_bad); end
      total++; if (ifa.bad_valid !== 1'b1) begin bad++; $display("FAIL t1_bad_valid: got %0b want 1", ifa.bad_valid); end
      total++; if (ifa.pass !== 1'b0 || ifa.busy !== 1'b0) begin
         bad++; $display("FAIL t1_pass_busy: got %0b/%0b want 0/0", ifa.pass, ifa.busy);
      end
      repeat (3) @(posedge clk);
      #1;
      total++; if (ifa.done !== 1'b0 || ifa.mismatch_count !== 3'd2 || ifa.first_bad !== 2'b01) begin
         bad++; $display("FAIL t1_hold: got done=%0b count=%0d first=%0h want 0/2/1",
                         ifa.done, ifa.mismatch_count, ifa.first_bad);
      end
   endtask

   task automatic test_equal_forms();
      int k;
      logic [1:0] exp_vec;
      mode_a = 1'b1;
      start_a();
      for (int s = 1; s <= 8; s++) begin
         exp_vec = 2'((s - 1) / 2);
         total++; if (ifa.vec !== exp_vec) begin
            bad++; $display("FAIL t2_vec_%0d: got %0h want %0h", s, ifa.vec, exp_vec);
         end
         if (s < 8) begin
            @(posedge clk); #1;
         end
      end
      wait_done_a(k);
      total++; if (k !== 1) begin bad++; $display("FAIL t2_done_edge: got %0d want 1", k); end
      total++; if (ifa.mismatch_count !== 3'd0 || ifa.bad_valid !== 1'b0 || ifa.pass !== 1'b1) begin
         bad++; $display("FAIL t2_result: got count=%0d valid=%0b pass=%0b want 0/0/1",
                         ifa.mismatch_count, ifa.bad_valid, ifa.pass);
      end
   endtask

   task automatic test_settle();
      int k = -1;
      ifb.start = 1'b1;
      @(posedge clk); #1;
      ifb.start = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk); #1;
         if (ifb.done) begin
            k = c;
            break;
         end
      end
      total++; if (k !== 16) begin bad++; $display("FAIL t3_latency: got %0d want 16", k); end
      total++; if (ifb.pass !== 1'b1) begin bad++; $display("FAIL t3_pass: got %0b want 1", ifb.pass); end
      @(posedge clk); #1;
      total++; if (ifb.done !== 1'b0) begin bad++; $display("FAIL t3_done_width: got %0b want 0", ifb.done); end
   endtask

   task automatic test_wide();
      int  k = -1;
      bit  seen_top = 1'b0;
      bit  wrapped = 1'b0;
      ifc.start = 1'b1;
      @(posedge clk); #1;
      ifc.start = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk); #1;
         if (ifc.vec == 3'b111) seen_top = 1'b1;
         else if (seen_top) wrapped = 1'b1;
         if (ifc.done) begin
            k = c;
            break;
         end
      end
      total++; if (k !== 16) begin bad++; $display("FAIL t4_latency: got %0d want 16", k); end
      total++; if (ifc.mismatch_count !== 4'd8) begin bad++; $display("FAIL t4_count: got %0d want 8", ifc.mismatch_count); end
      total++; if (ifc.first_bad !== 3'b000 || ifc.bad_valid !== 1'b1) begin
         bad++; $display("FAIL t4_first_bad: got %0h/%0b want 0/1", ifc.first_bad, ifc.bad_valid);
      end
      total++; if (ifc.vec !== 3'b111 || wrapped) begin
         bad++; $display("FAIL t4_no_wrap: got vec=%0h wrapped=%0b want 7/0", ifc.vec, wrapped);
      end
   endtask

   task automatic test_start_ignored();
      int ndone = 0;
      int first_k = -1;
      mode_a = 1'b0;
      start_a();
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk); #1;
         if (k == 3) ifa.start = 1'b1;
         if (k == 4) ifa.start = 1'b0;
         if (ifa.done) begin
            ndone++;
            if (first_k < 0) first_k = k;
         end
      end
      total++; if (ndone !== 1 || first_k !== 8) begin
         bad++; $display("FAIL t5_one_done: got n=%0d at=%0d want 1 at 8", ndone, first_k);
      end
      total++; if (ifa.mismatch_count !== 3'd2 || ifa.first_bad !== 2'b01) begin
         bad++; $display("FAIL t5_result: got count=%0d first=%0h want 2/1", ifa.mismatch_count, ifa.first_bad);
      end
   endtask

   task automatic test_reset_mid();
      int k;
      int ndone = 0;
      mode_a = 1'b0;
      start_a();
      repeat (5) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      total++; if (ifa.vec !== 2'b00 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
         bad++; $display("FAIL t6_abort_ctrl: got vec=%0h busy=%0b done=%0b want 0/0/0", ifa.vec, ifa.busy, ifa.done);
      end
      total++; if (ifa.mismatch_count !== 3'd0 || ifa.bad_valid !== 1'b0 || ifa.first_bad !== 2'b00) begin
         bad++; $display("FAIL t6_abort_result: got count=%0d valid=%0b first=%0h want 0/0/0",
                         ifa.mismatch_count, ifa.bad_valid, ifa.first_bad);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (ifa.done) ndone++;
      end
      total++; if (ndone !== 0) begin bad++; $display("FAIL t6_no_done: got %0d want 0", ndone); end
      start_a();
      wait_done_a(k);
      total++; if (k !== 8 || ifa.mismatch_count !== 3'd2 || ifa.first_bad !== 2'b01 || ifa.pass !== 1'b0) begin
         bad++; $display("FAIL t6_clean_rerun: got lat=%0d count=%0d first=%0h pass=%0b want 8/2/1/0",
                         k, ifa.mismatch_count, ifa.first_bad, ifa.pass);
      end
   endtask

   initial begin
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      ifc.start = 1'b0;
      mode_a    = 1'b0;
      test_reset();
      test_mismatch_basic();
      test_equal_forms();
      test_settle();
      test_wide();
      test_start_ignored();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
